flex_pts_serializer: RTL and testbench
======================================

// Module: flex_pts_serializer
// PURPOSE
//   Parameterised parallel-to-serial shifter. Successor to the fixed-mode PTS shift register.
//   Adds a valid/ready word input and a one-entry holding buffer, so back-to-back words
//   shift out with no gap. Also adds per-word length and per-word bit order, plus done
//   and underrun status. Sits between a byte/word source and a strobe-paced serial line
//   encoder (e.g. a TX bit-stuffer).
// PARAMETERS
//   NUM_BITS  8   max word width in bits (>=2)
//   IDLE_BIT  1   value driven on serial_out when idle; also the fill value shifted in
//   LEN_W     $clog2(NUM_BITS+1)   localparam, width of in_len
// PORTS
//   clk            in   1         system clock, rising edge
//   n_rst          in   1         asynchronous active-low reset
//   flush          in   1         sync clear of buffer and shifter
//   in_valid       in   1         source presents word
//   in_ready       out  1         holding buffer empty; accept on in_valid&&in_ready at edge
//   in_data        in   NUM_BITS  word, payload in bits [len-1:0]
//   in_len         in   LEN_W     bits to send; 0 or >NUM_BITS means NUM_BITS
//   in_msb_first   in   1         1: send bit len-1 first; 0: send bit 0 first
//   shift_strobe   in   1         advance one bit this cycle
//   serial_out     out  1         current bit on line
//   busy           out  1         shifter holds an active word
//   word_done      out  1         1-cycle pulse after the last bit of a word is shifted
//   underrun       out  1         1-cycle pulse: shift_strobe seen while not busy
// BEHAVIOUR
// - Reset (n_rst=0, async): hold empty, shifter IDLE, cnt=0, busy=0, in_ready=1,
//   serial_out=IDLE_BIT, word_done=0, underrun=0.
// - State: IDLE / SHIFT (busy = state==SHIFT). Remaining-bit counter cnt counts down from len.
// - in_ready = !hold_valid (combinational from register). An accept captures data, len and
//   msb_first into the hold buffer at the edge.
// - Load hold->shifter at an edge when hold_valid and either:
//   (a) state is IDLE; or
//   (b) SHIFT, shift_strobe=1 and cnt==1 (seamless reload).
//   On load: cnt=len (normalised); hold_valid clears; state=SHIFT.
//   Alignment: MSB-first left-justifies the payload (data << (NUM_BITS-len)).
//   LSB-first uses it as-is.
// - Latency: accept at edge N, load at edge N+1 if idle, first bit on serial_out after N+1.
// - serial_out (comb): SHIFT -> msb ? sr[NUM_BITS-1] : sr[0]; IDLE -> IDLE_BIT.
// - Shift: SHIFT and shift_strobe and cnt>1 -> shift toward the out end, fill with IDLE_BIT,
//   cnt--. With cnt==1 the strobe ends the word: reload per (b), else go IDLE.
// - word_done: registered; high the cycle after every edge that ends a word, including
//   on a seamless reload.
// - underrun: registered; high the cycle after an edge with shift_strobe=1 in IDLE.
//   The shifter ignores that strobe. A strobe in the same cycle as an idle load is an
//   underrun and is not applied to the new word.
// - Accept and load may occur at the same edge only if the hold was empty before it.
//   in_ready depends only on registered state.
// - flush=1 (sync, highest priority after reset): hold empty, IDLE, cnt=0; any accept or
//   strobe that cycle is dropped. word_done/underrun are 0 next cycle.
// - Reset mid-word: the word is lost; outputs take their reset values at once.
// TESTING
//   1 NUM_BITS=8, accept 0xA5 len=8 msb=1, strobe every cycle -> serial_out
//     1,0,1,0,0,1,0,1, then IDLE_BIT; one word_done pulse; busy high exactly 8 strobes.
//   2 0xA5 len=8 msb=0 -> 1,0,1,0,0,1,0,1 LSB-first; then 0x0B len=4 msb=1 -> 1,0,1,1;
//     in_len=0 behaves as len=8.
//   3 Back-to-back 0x0F,0xF0 (msb=1, second offered while first shifts, strobe each cycle)
//     -> 16 contiguous bits, busy never drops, two word_done pulses 8 cycles apart.
//   4 Strobe while idle -> underrun pulse, serial_out stays IDLE_BIT, next word unaffected.
//   5 flush after 3 of 8 bits with hold full -> next cycle busy=0, in_ready=1,
//     serial_out=IDLE_BIT, no word_done.
//   6 n_rst low mid-word then high, then a full word -> reset values at once; the new word
//     serialises correctly.

Source files
------------

// File: rtl/flex_pts_serializer_if.sv
// Word-side handshake between a byte/word source (master) and the serializer (slave).
// A word moves on a rising edge where in_valid and in_ready are both high.
interface flex_pts_serializer_if #(
    parameter int NUM_BITS = 8
);
    localparam int LEN_W = $clog2(NUM_BITS + 1);

    logic                in_valid;
    logic                in_ready;
    logic [NUM_BITS-1:0] in_data;
    logic [LEN_W-1:0]    in_len;
    logic                in_msb_first;

    modport master (
        output in_valid,
        output in_data,
        output in_len,
        output in_msb_first,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_len,
        input  in_msb_first,
        output in_ready
    );
endinterface

// File: rtl/flex_pts_serializer.sv
// Parallel-to-serial shifter with a one-word holding buffer, per-word length and bit
// order, strobe-paced output, and registered word_done/underrun status pulses.
module flex_pts_serializer #(
    parameter int NUM_BITS = 8,
    parameter bit IDLE_BIT = 1'b1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic flush,
    flex_pts_serializer_if.slave word_if,
    input  logic shift_strobe,
    output logic serial_out,
    output logic busy,
    output logic word_done,
    output logic underrun,
    output logic dbg_state_o
);
    localparam int LEN_W = $clog2(NUM_BITS + 1);
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(NUM_BITS);
    localparam logic [LEN_W-1:0] ONE_LEN  = LEN_W'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state_q;
    logic [NUM_BITS-1:0] sr_q;
    logic [LEN_W-1:0]    cnt_q;
    logic                msb_q;
    logic                hold_valid_q;
    logic [NUM_BITS-1:0] hold_data_q;
    logic [LEN_W-1:0]    hold_len_q;
    logic                hold_msb_q;
    logic                word_done_q;
    logic                underrun_q;

    logic [LEN_W-1:0]    hold_len_d;
    logic [NUM_BITS-1:0] load_sr_d;
    logic                accept_d;
    logic                last_bit_d;

    // Length is normalised on accept so the shifter only ever sees 1..NUM_BITS.
    assign hold_len_d = (word_if.in_len == '0 || word_if.in_len > FULL_LEN)
                        ? FULL_LEN : word_if.in_len;

    // MSB-first words are left-justified so the first bit always sits at the top.
    assign load_sr_d  = hold_msb_q ? (hold_data_q << (FULL_LEN - hold_len_q)) : hold_data_q;

    assign accept_d   = word_if.in_valid && !hold_valid_q;
    assign last_bit_d = (state_q == SHIFT) && shift_strobe && (cnt_q == ONE_LEN);

    assign word_if.in_ready = !hold_valid_q;
    assign busy             = (state_q == SHIFT);
    assign dbg_state_o      = state_q;
    assign word_done        = word_done_q;
    assign underrun         = underrun_q;
    assign serial_out       = (state_q == SHIFT) ? (msb_q ? sr_q[NUM_BITS-1] : sr_q[0])
                                                 : IDLE_BIT;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            sr_q         <= {NUM_BITS{IDLE_BIT}};
            cnt_q        <= '0;
            msb_q        <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_len_q   <= '0;
            hold_msb_q   <= 1'b0;
            word_done_q  <= 1'b0;
            underrun_q   <= 1'b0;
        end else if (flush) begin
            state_q      <= IDLE;
            sr_q         <= {NUM_BITS{IDLE_BIT}};
            cnt_q        <= '0;
            hold_valid_q <= 1'b0;
            word_done_q  <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            word_done_q <= last_bit_d;
            underrun_q  <= (state_q == IDLE) && shift_strobe;

            case (state_q)
                IDLE: begin
                    // A strobe arriving with the load is reported, never applied.
                    if (hold_valid_q) begin
                        state_q      <= SHIFT;
                        sr_q         <= load_sr_d;
                        cnt_q        <= hold_len_q;
                        msb_q        <= hold_msb_q;
                        hold_valid_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (shift_strobe) begin
                        if (cnt_q > ONE_LEN) begin
                            sr_q  <= msb_q ? {sr_q[NUM_BITS-2:0], IDLE_BIT}
                                           : {IDLE_BIT, sr_q[NUM_BITS-1:1]};
                            cnt_q <= cnt_q - ONE_LEN;
                        end else if (hold_valid_q) begin
                            sr_q         <= load_sr_d;
                            cnt_q        <= hold_len_q;
                            msb_q        <= hold_msb_q;
                            hold_valid_q <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            sr_q    <= {NUM_BITS{IDLE_BIT}};
                            cnt_q   <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase

            // Accept requires an empty hold, so it can never collide with a load.
            if (accept_d) begin
                hold_valid_q <= 1'b1;
                hold_data_q  <= word_if.in_data;
                hold_len_q   <= hold_len_d;
                hold_msb_q   <= word_if.in_msb_first;
            end
        end
    end
endmodule

// File: tb/tb_flex_pts_serializer.sv
// Directed bench for flex_pts_serializer (NUM_BITS=8, IDLE_BIT=1): inputs change on the
// falling edge, outputs are checked on the falling edge before the next drive.
module tb_flex_pts_serializer;
    localparam int NB = 8;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic flush = 1'b0;
    logic shift_strobe = 1'b0;
    logic serial_out, busy, word_done, underrun, dbg_state;

    int n_vec = 0;
    int n_err = 0;

    flex_pts_serializer_if #(.NUM_BITS(NB)) wif ();

    flex_pts_serializer #(.NUM_BITS(NB), .IDLE_BIT(1'b1)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .flush        (flush),
        .word_if      (wif.slave),
        .shift_strobe (shift_strobe),
        .serial_out   (serial_out),
        .busy         (busy),
        .word_done    (word_done),
        .underrun     (underrun),
        .dbg_state_o  (dbg_state)
    );

    always #5 clk = ~clk;

    // Offer a word, let it load, then strobe it out; exp holds the bits in send order
    // with the first bit at exp[n-1].
    task automatic run_word(input logic [7:0] data, input logic [3:0] len, input logic msb,
                            input logic [15:0] exp, input int n, input logic sol,
                            input string name);
        @(negedge clk);
        wif.in_valid = 1'b1; wif.in_data = data; wif.in_len = len; wif.in_msb_first = msb;
        shift_strobe = 1'b0;
        @(negedge clk);
        n_vec++;
        if (wif.in_ready !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s accept: in_ready=%b busy=%b required 0 0", name, wif.in_ready, busy);
        end
        wif.in_valid = 1'b0;
        shift_strobe = sol;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b1 || underrun !== sol) begin
            n_err++;
            $display("FAIL %s load: busy=%b underrun=%b required 1 %b", name, busy, underrun, sol);
        end
        for (int i = 0; i < n; i++) begin
            n_vec++;
            if (serial_out !== exp[n-1-i] || busy !== 1'b1 || word_done !== 1'b0) begin
                n_err++;
                $display("FAIL %s bit%0d: serial=%b busy=%b done=%b required %b 1 0",
                         name, i, serial_out, busy, word_done, exp[n-1-i]);
            end
            shift_strobe = 1'b1;
            @(negedge clk);
        end
        shift_strobe = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || word_done !== 1'b1 || serial_out !== 1'b1) begin
            n_err++;
            $display("FAIL %s end: busy=%b done=%b serial=%b required 0 1 1",
                     name, busy, word_done, serial_out);
        end
        @(negedge clk);
        n_vec++;
        if (word_done !== 1'b0 || underrun !== 1'b0) begin
            n_err++;
            $display("FAIL %s after: done=%b underrun=%b required 0 0", name, word_done, underrun);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        #12;
        n_vec++;
        if (busy !== 1'b0 || wif.in_ready !== 1'b1 || serial_out !== 1'b1 ||
            word_done !== 1'b0 || underrun !== 1'b0) begin
            n_err++;
            $display("FAIL reset: busy=%b ready=%b serial=%b done=%b under=%b required 0 1 1 0 0",
                     busy, wif.in_ready, serial_out, word_done, underrun);
        end
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_msb_first();
        run_word(8'hA5, 4'd8, 1'b1, 16'b10100101, 8, 1'b0, "msb_a5");
    endtask

    task automatic test_lsb_and_len();
        run_word(8'hA5, 4'd8, 1'b0, 16'b10100101, 8, 1'b0, "lsb_a5");
        run_word(8'h0B, 4'd4, 1'b1, 16'b1011, 4, 1'b0, "msb_0b_len4");
        run_word(8'hFB, 4'd4, 1'b0, 16'b1101, 4, 1'b0, "lsb_fb_len4");
        run_word(8'hC1, 4'd0, 1'b1, 16'b11000001, 8, 1'b0, "len0_c1");
        run_word(8'h5A, 4'd12, 1'b0, 16'b01011010, 8, 1'b0, "len12_5a");
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp = 16'b00001111_11110000;
        @(negedge clk);
        wif.in_valid = 1'b1; wif.in_data = 8'h0F; wif.in_len = 4'd8; wif.in_msb_first = 1'b1;
        @(negedge clk);
        wif.in_data = 8'hF0;
        wif.in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (serial_out !== exp[15-i] || busy !== 1'b1 || word_done !== (i == 8)) begin
                n_err++;
                $display("FAIL b2b bit%0d: serial=%b busy=%b done=%b required %b 1 %b",
                         i, serial_out, busy, word_done, exp[15-i], (i == 8));
            end
            if (i == 1 || i == 9) begin
                n_vec++;
                if (wif.in_ready !== (i == 9)) begin
                    n_err++;
                    $display("FAIL b2b ready%0d: in_ready=%b required %b", i, wif.in_ready, (i == 9));
                end
            end
            wif.in_valid = (i == 0);
            shift_strobe = 1'b1;
            @(negedge clk);
        end
        wif.in_valid = 1'b0;
        shift_strobe = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || word_done !== 1'b1) begin
            n_err++;
            $display("FAIL b2b end: busy=%b done=%b required 0 1", busy, word_done);
        end
        @(negedge clk);
    endtask

    task automatic test_underrun();
        @(negedge clk);
        shift_strobe = 1'b1;
        @(negedge clk);
        shift_strobe = 1'b0;
        n_vec++;
        if (underrun !== 1'b1 || serial_out !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL underrun pulse: under=%b serial=%b busy=%b required 1 1 0",
                     underrun, serial_out, busy);
        end
        @(negedge clk);
        n_vec++;
        if (underrun !== 1'b0) begin
            n_err++;
            $display("FAIL underrun clear: under=%b required 0", underrun);
        end
        run_word(8'h3C, 4'd8, 1'b1, 16'b00111100, 8, 1'b0, "after_underrun");
        run_word(8'h96, 4'd8, 1'b1, 16'b10010110, 8, 1'b1, "strobe_on_load");
    endtask

    task automatic test_flush();
        @(negedge clk);
        wif.in_valid = 1'b1; wif.in_data = 8'hA5; wif.in_len = 4'd8; wif.in_msb_first = 1'b1;
        @(negedge clk);
        wif.in_data = 8'h77;
        wif.in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            wif.in_valid = (i == 0);
            shift_strobe = 1'b1;
            @(negedge clk);
        end
        n_vec++;
        if (wif.in_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL flush pre: in_ready=%b busy=%b required 0 1", wif.in_ready, busy);
        end
        flush = 1'b1;
        wif.in_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wif.in_valid = 1'b0;
        shift_strobe = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || wif.in_ready !== 1'b1 || serial_out !== 1'b1 ||
            word_done !== 1'b0 || underrun !== 1'b0) begin
            n_err++;
            $display("FAIL flush: busy=%b ready=%b serial=%b done=%b under=%b required 0 1 1 0 0",
                     busy, wif.in_ready, serial_out, word_done, underrun);
        end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || word_done !== 1'b0) begin
            n_err++;
            $display("FAIL flush hold: busy=%b done=%b required 0 0", busy, word_done);
        end
        run_word(8'h0B, 4'd4, 1'b1, 16'b1011, 4, 1'b0, "after_flush");
    endtask

    task automatic test_reset_mid_word();
        @(negedge clk);
        wif.in_valid = 1'b1; wif.in_data = 8'hA5; wif.in_len = 4'd8; wif.in_msb_first = 1'b1;
        @(negedge clk);
        wif.in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            shift_strobe = 1'b1;
            @(negedge clk);
        end
        shift_strobe = 1'b0;
        #2;
        n_rst = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || wif.in_ready !== 1'b1 || serial_out !== 1'b1 || word_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: busy=%b ready=%b serial=%b done=%b required 0 1 1 0",
                     busy, wif.in_ready, serial_out, word_done);
        end
        @(negedge clk);
        n_rst = 1'b1;
        run_word(8'h3C, 4'd8, 1'b0, 16'b00111100, 8, 1'b0, "after_reset");
    endtask

    initial begin
        wif.in_valid = 1'b0; wif.in_data = '0; wif.in_len = '0; wif.in_msb_first = 1'b0;
        test_reset();
        test_msb_first();
        test_lsb_and_len();
        test_back_to_back();
        test_underrun();
        test_flush();
        test_reset_mid_word();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
